// File: rtl/sram_access_seq_pkg.sv
// Shared definitions for the vector SRAM access sequencer: bank geometry,
// requester IDs, FSM state encoding and the round-robin pick function.
package sram_access_seq_pkg;

  // Bank geometry: four 71V016SA10 chips, 16 bits each, side by side.
  localparam int SRAM_ADDR_W = 16;
  localparam int SRAM_DATA_W = 64;
  localparam int CHIP_COUNT  = 4;
  localparam int CHIP_W      = SRAM_DATA_W / CHIP_COUNT;

  // Requester identifiers, also used as the round-robin pointer value.
  localparam logic PORT_HOST = 1'b0;
  localparam logic PORT_TEST = 1'b1;

  // Width of the strobe-length counter; generous for any sane cycle count.
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WRITE   = 3'd2,
    ST_RECOVER = 3'd3,
    ST_READ    = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_DONE    = 3'd6
  } seq_state_e;

  // Pick a requester. With both requesting, the pointer names the port that
  // was not granted last; with one requesting, that one wins outright.
  function automatic logic rr_pick(input logic [1:0] req, input logic ptr);
    logic pick;
    if (req[0] && req[1]) begin
      pick = ptr;
    end else begin
      pick = req[1] ? PORT_TEST : PORT_HOST;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sram_access_seq_if.sv
// Requester-side bus of the SRAM access sequencer: host (h_) and tester (t_)
// request/ack handshakes plus the shared read-data return.
interface sram_access_seq_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);

  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_ack;
  logic              h_err;

  logic              t_req;
  logic              t_we;
  logic [ADDR_W-1:0] t_addr;
  logic [DATA_W-1:0] t_wdata;
  logic              t_ack;
  logic              t_err;

  logic [DATA_W-1:0] rdata;

  // Requester side: drives requests, receives completions and read data.
  modport master (
    output h_req, h_we, h_addr, h_wdata,
    output t_req, t_we, t_addr, t_wdata,
    input  h_ack, h_err, t_ack, t_err, rdata
  );

  // Sequencer side.
  modport slave (
    input  h_req, h_we, h_addr, h_wdata,
    input  t_req, t_we, t_addr, t_wdata,
    output h_ack, h_err, t_ack, t_err, rdata
  );

endinterface

// File: rtl/sram_rr_arb2.sv
// Two-requester round-robin arbiter. The grant is combinational and only
// offered while en is high; the pointer moves to the other port on each grant.
module sram_rr_arb2
  import sram_access_seq_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic ptr_q;

  assign gnt_valid = en && (|req);
  assign gnt_id    = rr_pick(req, ptr_q);

  // Point at the port that did not win, so a contended pair alternates.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= PORT_HOST;
    end else if (gnt_valid) begin
      ptr_q <= ~gnt_id;
    end
  end

endmodule

// File: rtl/sram_access_seq.sv
// Access sequencer for the four-chip 64K x 64 vector SRAM bank. Arbitrates
// host and tester requests and produces registered OE/CS/WE strobes, address,
// write data and drive enable. The strobes pass through one external register
// stage before the pins, which is why reads spend an extra CAPTURE cycle
// before sampling the data bus.
module sram_access_seq
  import sram_access_seq_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_allow,
  sram_access_seq_if.slave  req_if,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              oe_bar_in,
  output logic              cs_bar_in,
  output logic              we_bar_in,
  output logic              busy
);

  // Last strobe-cycle index for write and read phases.
  localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

  seq_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              gnt_id_q;
  logic              we_q;

  logic              oe_bar_q;
  logic              cs_bar_q;
  logic              we_bar_q;
  logic              dq_oe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dq_out_q;
  logic [DATA_W-1:0] rdata_q;
  logic              busy_q;
  logic              h_ack_q;
  logic              h_err_q;
  logic              t_ack_q;
  logic              t_err_q;

  logic              gnt_valid;
  logic              gnt_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Requests are only offered to the arbiter in IDLE; everything else waits.
  sram_rr_arb2 u_arb (
    .CLK       (CLK),
    .RST       (RST),
    .req       ({req_if.t_req, req_if.h_req}),
    .en        (state_q == ST_IDLE),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Route the granted port's request fields.
  always_comb begin
    sel_we    = req_if.h_we;
    sel_addr  = req_if.h_addr;
    sel_wdata = req_if.h_wdata;
    if (gnt_id == PORT_TEST) begin
      sel_we    = req_if.t_we;
      sel_addr  = req_if.t_addr;
      sel_wdata = req_if.t_wdata;
    end
  end

  // Access FSM; every output register is updated alongside the state so each
  // strobe is valid for exactly the cycles its state occupies.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gnt_id_q <= PORT_HOST;
      we_q     <= 1'b0;
      oe_bar_q <= 1'b1;
      cs_bar_q <= 1'b1;
      we_bar_q <= 1'b1;
      dq_oe_q  <= 1'b0;
      addr_q   <= '0;
      dq_out_q <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      h_ack_q  <= 1'b0;
      h_err_q  <= 1'b0;
      t_ack_q  <= 1'b0;
      t_err_q  <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses.
      h_ack_q <= 1'b0;
      h_err_q <= 1'b0;
      t_ack_q <= 1'b0;
      t_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            gnt_id_q <= gnt_id;
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            dq_out_q <= sel_wdata;
            busy_q   <= 1'b1;
            if (sel_we && !wr_allow) begin
              // Refused write: complete immediately, bus untouched.
              state_q <= ST_DONE;
              h_ack_q <= (gnt_id == PORT_HOST);
              h_err_q <= (gnt_id == PORT_HOST);
              t_ack_q <= (gnt_id == PORT_TEST);
              t_err_q <= (gnt_id == PORT_TEST);
            end else begin
              state_q  <= ST_SETUP;
              cs_bar_q <= 1'b0;
              dq_oe_q  <= sel_we;
            end
          end
        end

        ST_SETUP: begin
          cnt_q <= '0;
          if (we_q) begin
            state_q  <= ST_WRITE;
            we_bar_q <= 1'b0;
          end else begin
            state_q  <= ST_READ;
            oe_bar_q <= 1'b0;
            dq_oe_q  <= 1'b0;
          end
        end

        ST_WRITE: begin
          if (cnt_q == WR_LAST) begin
            // Release WE but keep driving data for hold time.
            state_q  <= ST_RECOVER;
            we_bar_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RECOVER: begin
          state_q  <= ST_DONE;
          cs_bar_q <= 1'b1;
          dq_oe_q  <= 1'b0;
          h_ack_q  <= (gnt_id_q == PORT_HOST);
          t_ack_q  <= (gnt_id_q == PORT_TEST);
        end

        ST_READ: begin
          if (cnt_q == RD_LAST) begin
            state_q <= ST_CAPTURE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_CAPTURE: begin
          // Pins lag our strobes by one cycle; data is settled here.
          state_q  <= ST_DONE;
          rdata_q  <= sram_dq_in;
          cs_bar_q <= 1'b1;
          oe_bar_q <= 1'b1;
          h_ack_q  <= (gnt_id_q == PORT_HOST);
          t_ack_q  <= (gnt_id_q == PORT_TEST);
        end

        ST_DONE: begin
          // Requests are deliberately not sampled here.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q  <= ST_IDLE;
          oe_bar_q <= 1'b1;
          cs_bar_q <= 1'b1;
          we_bar_q <= 1'b1;
          dq_oe_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign sram_dq_out   = dq_out_q;
  assign sram_dq_oe    = dq_oe_q;
  assign sram_addr     = addr_q;
  assign oe_bar_in     = oe_bar_q;
  assign cs_bar_in     = cs_bar_q;
  assign we_bar_in     = we_bar_q;
  assign busy          = busy_q;

  assign req_if.h_ack  = h_ack_q;
  assign req_if.h_err  = h_err_q;
  assign req_if.t_ack  = t_ack_q;
  assign req_if.t_err  = t_err_q;
  assign req_if.rdata  = rdata_q;

endmodule

// File: tb/tb_sram_access_seq.sv
// Directed bench for sram_access_seq with a one-cycle strobe register stage
// and a small SRAM behavioural model.
module tb_sram_access_seq;

  logic        CLK;
  logic        RST;
  logic        wr_allow;
  logic [63:0] sram_dq_in;
  logic [63:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_addr;
  logic        oe_bar_in;
  logic        cs_bar_in;
  logic        we_bar_in;
  logic        busy;

  int n_checks;
  int n_fail;

  sram_access_seq_if #(.ADDR_W(16), .DATA_W(64)) bus ();

  sram_access_seq #(
    .ADDR_W(16), .DATA_W(64), .WR_CYCLES(2), .RD_CYCLES(2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .wr_allow    (wr_allow),
    .req_if      (bus.slave),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_addr   (sram_addr),
    .oe_bar_in   (oe_bar_in),
    .cs_bar_in   (cs_bar_in),
    .we_bar_in   (we_bar_in),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Strobe register stage and SRAM model.
  logic        oe_pin, cs_pin, we_pin;
  logic [15:0] addr_pin;
  logic [63:0] dq_pin;
  logic [63:0] mem [0:255];

  always @(posedge CLK) begin
    if (RST) begin
      oe_pin <= 1'b1; cs_pin <= 1'b1; we_pin <= 1'b1;
      addr_pin <= '0; dq_pin <= '0;
    end else begin
      oe_pin <= oe_bar_in; cs_pin <= cs_bar_in; we_pin <= we_bar_in;
      addr_pin <= sram_addr; dq_pin <= sram_dq_out;
      if (!cs_pin && !we_pin) mem[addr_pin[7:0]] <= dq_pin;
    end
  end

  assign sram_dq_in = (!cs_pin && !oe_pin) ? mem[addr_pin[7:0]] : 64'h0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One access from IDLE; bit k of each mask records cycle k after the
  // request (grant edge ends cycle 0). Request drops when its ack is seen.
  task automatic run_access(input logic port, input logic we, input logic [15:0] addr,
                            input logic [63:0] data,
                            output logic [15:0] we_m, output logic [15:0] oe_m,
                            output logic [15:0] cs_m, output logic [15:0] dqoe_m,
                            output logic [15:0] ack_m, output logic [15:0] oth_m,
                            output logic [15:0] err_m, output logic [15:0] busy_m,
                            output logic [63:0] rd);
    we_m = '0; oe_m = '0; cs_m = '0; dqoe_m = '0;
    ack_m = '0; oth_m = '0; err_m = '0; busy_m = '0; rd = '0;
    @(negedge CLK);
    if (port == 1'b0) begin
      bus.h_we = we; bus.h_addr = addr; bus.h_wdata = data; bus.h_req = 1'b1;
    end else begin
      bus.t_we = we; bus.t_addr = addr; bus.t_wdata = data; bus.t_req = 1'b1;
    end
    for (int k = 1; k < 16; k++) begin
      @(negedge CLK);
      we_m[k]   = !we_bar_in;
      oe_m[k]   = !oe_bar_in;
      cs_m[k]   = !cs_bar_in;
      dqoe_m[k] = sram_dq_oe;
      busy_m[k] = busy;
      ack_m[k]  = port ? bus.t_ack : bus.h_ack;
      oth_m[k]  = port ? bus.h_ack : bus.t_ack;
      err_m[k]  = port ? bus.t_err : bus.h_err;
      if (ack_m[k]) begin
        rd = bus.rdata;
        if (port == 1'b0) bus.h_req = 1'b0; else bus.t_req = 1'b0;
      end
    end
  endtask

  logic [15:0] we_m, oe_m, cs_m, dqoe_m, ack_m, oth_m, err_m, busy_m;
  logic [63:0] rd;
  logic [1:0]  seq [0:3];
  int          n_acks;
  int          dbl;
  int          rst_acks;

  initial begin
    n_checks = 0; n_fail = 0;
    RST = 1'b1; wr_allow = 1'b1;
    bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0;
    bus.t_req = 0; bus.t_we = 0; bus.t_addr = '0; bus.t_wdata = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_strobes", {61'h0, oe_bar_in, cs_bar_in, we_bar_in}, 64'h7);
    check_val("rst_dq_oe_busy", {62'h0, sram_dq_oe, busy}, 64'h0);
    check_val("rst_acks_errs", {60'h0, bus.h_ack, bus.h_err, bus.t_ack, bus.t_err}, 64'h0);
    check_val("rst_rdata", bus.rdata, 64'h0);
    check_val("rst_addr_dq", {32'h0, sram_addr, 16'h0} | 64'(sram_dq_out), 64'h0);
    RST = 1'b0;

    // Host write.
    run_access(1'b0, 1'b1, 16'h0010, 64'h1122334455667788,
               we_m, oe_m, cs_m, dqoe_m, ack_m, oth_m, err_m, busy_m, rd);
    check_val("hw_we_low", 64'(we_m), 64'h000C);
    check_val("hw_oe_low", 64'(oe_m), 64'h0000);
    check_val("hw_cs_low", 64'(cs_m), 64'h001E);
    check_val("hw_dq_oe", 64'(dqoe_m), 64'h001E);
    check_val("hw_ack", 64'(ack_m), 64'h0020);
    check_val("hw_err", 64'(err_m), 64'h0000);
    check_val("hw_other_ack", 64'(oth_m), 64'h0000);
    check_val("hw_addr", 64'(sram_addr), 64'h0010);
    check_val("hw_dq_out", sram_dq_out, 64'h1122334455667788);

    // Host read of the same word; request held through the ack cycle.
    run_access(1'b0, 1'b0, 16'h0010, 64'h0,
               we_m, oe_m, cs_m, dqoe_m, ack_m, oth_m, err_m, busy_m, rd);
    check_val("hr_oe_low", 64'(oe_m), 64'h001C);
    check_val("hr_we_low", 64'(we_m), 64'h0000);
    check_val("hr_dq_oe", 64'(dqoe_m), 64'h0000);
    check_val("hr_ack", 64'(ack_m), 64'h0020);
    check_val("hr_rdata", rd, 64'h1122334455667788);
    check_val("hr_busy_no_regrant", 64'(busy_m), 64'h003E);
    check_val("hr_rdata_hold", bus.rdata, 64'h1122334455667788);

    // Tester write refused.
    wr_allow = 1'b0;
    run_access(1'b1, 1'b1, 16'h0020, 64'hDEADBEEF00000000,
               we_m, oe_m, cs_m, dqoe_m, ack_m, oth_m, err_m, busy_m, rd);
    check_val("tw_ref_ack", 64'(ack_m), 64'h0002);
    check_val("tw_ref_err", 64'(err_m), 64'h0002);
    check_val("tw_ref_we", 64'(we_m), 64'h0000);
    check_val("tw_ref_cs", 64'(cs_m), 64'h0000);
    check_val("tw_ref_other", 64'(oth_m), 64'h0000);
    wr_allow = 1'b1;

    // Both request together and keep requesting: grants must alternate.
    @(negedge CLK);
    bus.h_we = 0; bus.h_addr = 16'h0010; bus.t_we = 0; bus.t_addr = 16'h0011;
    bus.h_req = 1; bus.t_req = 1;
    n_acks = 0; dbl = 0;
    for (int c = 0; c < 60 && n_acks < 4; c++) begin
      @(negedge CLK);
      if (bus.h_ack && bus.t_ack) dbl++;
      if (bus.h_ack || bus.t_ack) begin
        seq[n_acks] = bus.t_ack ? 2'd1 : 2'd0;
        n_acks++;
      end
    end
    bus.h_req = 0; bus.t_req = 0;
    check_val("rr_ack_count", 64'(n_acks), 64'd4);
    check_val("rr_double_ack", 64'(dbl), 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < n_acks) check_val($sformatf("rr_grant%0d", i), 64'(seq[i]), 64'(i % 2));
    end
    repeat (3) @(negedge CLK);

    // Reset during WRITE.
    @(negedge CLK);
    bus.h_we = 1; bus.h_addr = 16'h0030; bus.h_wdata = 64'hA5A5; bus.h_req = 1;
    @(negedge CLK);           // SETUP
    @(negedge CLK);           // WRITE
    check_val("rw_in_write", 64'(we_bar_in), 64'h0);
    RST = 1'b1; bus.h_req = 0;
    @(negedge CLK);
    check_val("rw_strobes", {61'h0, oe_bar_in, cs_bar_in, we_bar_in}, 64'h7);
    check_val("rw_dq_oe_busy_ack", {61'h0, sram_dq_oe, busy, bus.h_ack}, 64'h0);
    RST = 1'b0;
    rst_acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (bus.h_ack || bus.t_ack || busy) rst_acks++;
    end
    check_val("rw_no_ack_after", 64'(rst_acks), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_access_seq.md
Name: sram_access_seq

Overview:
- Sequences all accesses to the four-chip 64K x 64-bit vector SRAM bank (71V016SA10, 16 bits per chip, 10 ns).
- Arbitrates between two requesters: host loader port (h_) and tester vector-apply port (t_).
- Generates the active-low OE/CS/WE strobes, address, write-data drive enable and read capture.
- Strobes feed the downstream strobe register stage, which adds exactly one CLK of delay before the pins.

Parameters:
- ADDR_W, 16, SRAM word address width.
- DATA_W, 64, bank data width (4 x 16).
- WR_CYCLES, 2, CLKs WE is held low per write (>=1).
- RD_CYCLES, 2, CLKs OE is held low before capture (>=1).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset RST, synchronous, active-high.
- wr_allow  in  1  1 = SRAM writes permitted (vector-load mode).
- h_req  in  1  host request; level, held until h_ack.
- h_we  in  1  host request type: 1 = write, 0 = read.
- h_addr  in  ADDR_W  host address.
- h_wdata  in  DATA_W  host write data.
- h_ack  out  1  one-cycle completion pulse.
- h_err  out  1  valid with h_ack; write refused.
- t_req, t_we, t_addr, t_wdata, t_ack, t_err: same as the h_ ports, for the tester.
- rdata  out  DATA_W  read data; valid in the ack cycle, holds until the next read capture.
- sram_dq_in  in  DATA_W  data from the SRAM pins.
- sram_dq_out  out  DATA_W  data to the SRAM pins.
- sram_dq_oe  out  1  pin driver enable.
- sram_addr  out  ADDR_W  SRAM address.
- oe_bar_in  out  1  OE strobe to the register stage.
- cs_bar_in  out  1  CS strobe to the register stage.
- we_bar_in  out  1  WE strobe to the register stage.
- busy  out  1  state != IDLE.

Behaviour:
- All outputs are registered.
- Reset values: oe/cs/we_bar_in = 1, sram_dq_oe = 0, acks = 0, errs = 0, busy = 0, rdata = 0, sram_addr = 0, sram_dq_out = 0. State = IDLE, round-robin pointer = host.
- RST mid-access aborts at the next edge: strobes deasserted, no ack issued.
- FSM states: IDLE, SETUP, WRITE, RECOVER, READ, CAPTURE, DONE.
- IDLE:
  - If any req is high, grant. When both are high, the grant goes to the port not granted last (round-robin); pointer updates on grant.
  - Latch we/addr/wdata of the granted port into sram_addr/sram_dq_out.
  - A write while wr_allow = 0 goes directly to DONE with err = 1 and no strobe activity.
- SETUP (1 CLK): cs_bar_in = 0. For a write, sram_dq_oe = 1. Next state is WRITE or READ.
- WRITE (WR_CYCLES CLKs): cs_bar_in = 0, we_bar_in = 0, oe_bar_in = 1, dq driven.
- RECOVER (1 CLK): we_bar_in = 1, cs_bar_in = 0, dq still driven (hold time). Next state is DONE.
- READ (RD_CYCLES CLKs): cs_bar_in = 0, oe_bar_in = 0, sram_dq_oe = 0.
- CAPTURE (1 CLK): cs_bar_in = 0, oe_bar_in = 0. This covers the register-stage delay. rdata <= sram_dq_in on the edge leaving CAPTURE.
- DONE (1 CLK):
  - All strobes high, sram_dq_oe = 0.
  - Ack pulse on the granted port; err per above.
  - New requests are not sampled in DONE, so a requester dropping req after ack is never double-granted.
- Latency, grant edge to ack cycle: write = WR_CYCLES + 3 CLKs; read = RD_CYCLES + 3 CLKs; refused write = 1 CLK.
- we_bar_in and oe_bar_in are never both 0.
- sram_dq_oe is never 1 while oe_bar_in = 0, including the cycle after READ entry.
- wr_allow is sampled only at grant; a change mid-access does not affect the access in flight.
- Requests arriving while busy wait; request inputs are ignored except at IDLE.
- Addresses are used as given; there is no wrap or increment (callers sequence addresses).

Decomposition:
- Shared package: state encoding enum; port-ID constants (PORT_HOST = 0, PORT_TEST = 1); SRAM geometry constants (ADDR_W, DATA_W, CHIP_COUNT = 4).
- One natural sub-module: sram_rr_arb2, a two-requester round-robin arbiter with a grant-enable input, instantiated by sram_access_seq.

Test Plan:
- Host write 0x0010 <= 0x1122334455667788, wr_allow = 1, defaults -> SETUP at cycle 1, we_bar_in low cycles 2-3, dq_oe high cycles 1-4, h_ack in cycle 5, h_err = 0.
- Host read 0x0010 with a model returning the same word after the one-cycle strobe delay -> oe_bar_in low cycles 2-4, h_ack in cycle 5, rdata = 0x1122334455667788.
- h_req and t_req rise together, both held and re-requested repeatedly -> grants alternate host, test, host, test; no ack ever lands on the non-granted port.
- Tester write with wr_allow = 0 -> t_ack, t_err = 1 one cycle after grant; we_bar_in and cs_bar_in stay 1 throughout.
- RST asserted during the WRITE state -> next cycle all strobes = 1, dq_oe = 0, busy = 0, no ack.
- Requester holds req through the ack/DONE cycle, then drops it -> no second grant; IDLE remains and busy = 0.
